// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL lock / reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABILIZE = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } seq_state_t;

  localparam int unsigned RELOCK_W = 8;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_reset_seq_sync_bit.sv
// Multi-flop synchroniser for a single asynchronous level.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the async level through the chain; reset clears every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Qualifies the PLL lock flag, sequences a synchronous-release reset for the
// 96 MHz domain, generates a 12 MHz clock enable and counts lock losses.
module pll_lock_reset_seq
  import pll_seq_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned RST_HOLD_CYCLES    = 16,
  parameter int unsigned LOSS_FILTER        = 4,
  parameter int unsigned CE_DIV             = 8
) (
  input  logic                clk_96MHz,
  input  logic                rst,
  input  logic                locked,
  output logic                rst_out,
  output logic                ready,
  output logic                ce_12MHz,
  output logic [RELOCK_W-1:0] relock_count,
  output logic [1:0]          state_dbg
);

  localparam int unsigned CNT_MAX = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ?
                                    LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int unsigned CNT_W  = cnt_width(CNT_MAX);
  localparam int unsigned LOSS_W = cnt_width(LOSS_FILTER);
  localparam int unsigned DIV_W  = cnt_width(CE_DIV);

  logic lock_s;

  seq_state_t          state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [LOSS_W-1:0]   loss, loss_n;
  logic [DIV_W-1:0]    div, div_n;
  logic [RELOCK_W-1:0] relock_n;
  logic                ce_n;

  sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk_96MHz),
    .rst (rst),
    .d   (locked),
    .q   (lock_s)
  );

  // Next-state, counter and output decode; outputs follow the next state so
  // they are registered alongside it.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    loss_n   = '0;
    div_n    = '0;
    ce_n     = 1'b0;
    relock_n = relock_count;
    case (state)
      WAIT_LOCK: begin
        cnt_n = '0;
        if (lock_s) state_n = STABILIZE;
      end
      STABILIZE: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_n = HOLD;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_n = WAIT_LOCK;
          cnt_n   = '0;
        end else if (cnt == CNT_W'(RST_HOLD_CYCLES - 1)) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        cnt_n = '0;
        if (!lock_s) begin
          if (loss == LOSS_W'(LOSS_FILTER - 1)) begin
            state_n = WAIT_LOCK;
            if (relock_count != '1) relock_n = relock_count + 1'b1;
          end else begin
            loss_n = loss + 1'b1;
          end
        end
      end
      default: begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
    endcase
    // Divider only advances while staying in RUN, so the pulse is dropped on
    // the exit edge and restarts from zero on every entry.
    if (state == RUN && state_n == RUN) begin
      if (div == DIV_W'(CE_DIV - 1)) begin
        ce_n = 1'b1;
      end else begin
        div_n = div + 1'b1;
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk_96MHz or posedge rst) begin
    if (rst) begin
      state        <= WAIT_LOCK;
      cnt          <= '0;
      loss         <= '0;
      div          <= '0;
      relock_count <= '0;
      rst_out      <= 1'b1;
      ready        <= 1'b0;
      ce_12MHz     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      loss         <= loss_n;
      div          <= div_n;
      relock_count <= relock_n;
      rst_out      <= (state_n != RUN);
      ready        <= (state_n == RUN);
      ce_12MHz     <= ce_n;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Directed bench for pll_lock_reset_seq: expectations are queued as stimulus
// is applied and popped when the corresponding DUT cycle has completed.
module tb_pll_lock_reset_seq;

  localparam int unsigned SS  = 2;
  localparam int unsigned LSC = 16;
  localparam int unsigned RHC = 4;
  localparam int unsigned LF  = 3;
  localparam int unsigned CED = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       locked;
  logic       rst_out;
  logic       ready;
  logic       ce_12MHz;
  logic [7:0] relock_count;
  logic [1:0] state_dbg;

  pll_lock_reset_seq #(
    .SYNC_STAGES        (SS),
    .LOCK_STABLE_CYCLES (LSC),
    .RST_HOLD_CYCLES    (RHC),
    .LOSS_FILTER        (LF),
    .CE_DIV             (CED)
  ) dut (
    .clk_96MHz    (clk),
    .rst          (rst),
    .locked       (locked),
    .rst_out      (rst_out),
    .ready        (ready),
    .ce_12MHz     (ce_12MHz),
    .relock_count (relock_count),
    .state_dbg    (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [12:0] v;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   bad    = 0;
  int   ecount = 0;

  // {state, rst_out, ready, ce, relock_count}
  function automatic logic [12:0] pk(input logic [1:0] st, input logic ro,
                                     input logic rdy, input logic ce,
                                     input logic [7:0] rc);
    return {st, ro, rdy, ce, rc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ecount++;
  endtask

  // Advance until edge e (numbered from 0) has just occurred.
  task automatic goto(input int e);
    while (ecount < e + 1) tick();
  endtask

  task automatic push_exp(input string tag, input logic [12:0] v);
    exp_t x;
    x.tag = tag;
    x.v   = v;
    q.push_back(x);
  endtask

  task automatic check();
    exp_t        x;
    logic [12:0] obs;
    x   = q.pop_front();
    obs = {state_dbg, rst_out, ready, ce_12MHz, relock_count};
    total++;
    assert (obs === x.v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h (edge %0d)", x.tag, obs, x.v, ecount - 1);
    end
  endtask

  task automatic expect_at(input string tag, input int e, input logic [12:0] v);
    push_exp(tag, v);
    goto(e);
    check();
  endtask

  initial begin
    int          n;
    logic [7:0]  exp_rc;
    logic        exp_ce;

    rst    = 1'b1;
    locked = 1'b1;

    // Reset held with the PLL already locked: nothing may leave WAIT_LOCK.
    for (int i = 0; i < 5; i++) begin
      push_exp("reset_hold", pk(2'd0, 1'b1, 1'b0, 1'b0, 8'd0));
      tick();
      check();
    end

    // Clean lock: edge 0 is the first edge after release.
    rst    = 1'b0;
    ecount = 0;
    expect_at("clean_wait",  1,  pk(2'd0, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at("clean_stab",  2,  pk(2'd1, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at("clean_stab2", 17, pk(2'd1, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at("clean_hold",  18, pk(2'd2, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at("clean_hold2", 21, pk(2'd2, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at("clean_run",   SS + LSC + RHC, pk(2'd3, 1'b0, 1'b1, 1'b0, 8'd0));
    for (int e = 23; e <= 47; e++) begin
      exp_ce = ((e - 22) % CED == 0);
      expect_at("clean_ce", e, pk(2'd3, 1'b0, 1'b1, exp_ce, 8'd0));
    end

    // Asynchronous reset mid-RUN must act before the next edge.
    #2;
    rst = 1'b1;
    #1;
    push_exp("async_rst", pk(2'd0, 1'b1, 1'b0, 1'b0, 8'd0));
    check();
    for (int i = 0; i < 3; i++) begin
      push_exp("async_rst_hold", pk(2'd0, 1'b1, 1'b0, 1'b0, 8'd0));
      tick();
      check();
    end

    // Unstable lock: one-cycle drop while STABILIZE cnt=10.
    rst    = 1'b0;
    ecount = 0;
    expect_at("unst_stab", 2,  pk(2'd1, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at("unst_cnt",  12, pk(2'd1, 1'b1, 1'b0, 1'b0, 8'd0));
    locked = 1'b0;
    goto(13);
    locked = 1'b1;
    expect_at("unst_back",  15, pk(2'd0, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at("unst_restb", 16, pk(2'd1, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at("unst_hold",  35, pk(2'd2, 1'b1, 1'b0, 1'b0, 8'd0));
    expect_at("unst_run",   14 + SS + LSC + RHC, pk(2'd3, 1'b0, 1'b1, 1'b0, 8'd0));

    // Two-cycle glitch in RUN: no visible effect, cadence from edge 36 intact.
    for (int e = 37; e <= 63; e++) begin
      exp_ce = ((e - 36) % CED == 0);
      expect_at("glitch_run", e, pk(2'd3, 1'b0, 1'b1, exp_ce, 8'd0));
      if (e == 45) locked = 1'b0;
      if (e == 47) locked = 1'b1;
    end

    // Sustained loss: third synced-low edge lands on a would-be ce pulse.
    locked = 1'b0;
    expect_at("loss_pre",  67, pk(2'd3, 1'b0, 1'b1, 1'b0, 8'd0));
    expect_at("loss_exit", 68, pk(2'd0, 1'b1, 1'b0, 1'b0, 8'd1));

    // Loss during HOLD: back to WAIT_LOCK without counting, then full relock.
    goto(70);
    locked = 1'b1;
    expect_at("hold_stab", 73, pk(2'd1, 1'b1, 1'b0, 1'b0, 8'd1));
    expect_at("hold_in",   89, pk(2'd2, 1'b1, 1'b0, 1'b0, 8'd1));
    locked = 1'b0;
    expect_at("hold_still", 91, pk(2'd2, 1'b1, 1'b0, 1'b0, 8'd1));
    expect_at("hold_drop",  92, pk(2'd0, 1'b1, 1'b0, 1'b0, 8'd1));
    locked = 1'b1;
    expect_at("relock_hold", 114, pk(2'd2, 1'b1, 1'b0, 1'b0, 8'd1));
    expect_at("relock_run",  93 + SS + LSC + RHC, pk(2'd3, 1'b0, 1'b1, 1'b0, 8'd1));

    // Saturation: repeated loss/relock cycles, count must stop at 255.
    exp_rc = 8'd1;
    for (int i = 0; i < 260; i++) begin
      locked = 1'b0;
      n = 0;
      while (state_dbg == 2'd3 && n < 10) begin
        tick();
        n++;
      end
      if (exp_rc != 8'hFF) exp_rc = exp_rc + 8'd1;
      push_exp("sat_loss", pk(2'd0, 1'b1, 1'b0, 1'b0, exp_rc));
      check();
      locked = 1'b1;
      n = 0;
      while (state_dbg != 2'd3 && n < 40) begin
        tick();
        n++;
      end
      push_exp("sat_run", pk(2'd3, 1'b0, 1'b1, 1'b0, exp_rc));
      check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
